uart_param_framer: RTL and testbench

- Upstream stage of the UDP transmit path. Sits between uart_receive and the parameter/data-generation logic that feeds ethernet_udp_transmit.
- Assembles a framed, checksummed parameter block from the UART byte stream: sync byte, payload, checksum.
- Publishes the parameter vector and a one-cycle valid pulse only for good frames.
- Adds resynchronisation and inter-byte timeout, so a dropped UART byte cannot permanently misalign the parameter fields.

---
 rtl/uart_param_framer.sv | 174 +++++++++++++++++
 tb/tb_uart_param_framer.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_param_framer.sv
// uart_param_framer: assembles a framed, checksummed parameter block from a
// UART byte stream (SYNC_BYTE, PARAM_BYTES payload bytes, checksum byte) and
// publishes the payload only when the 8-bit sum of payload plus checksum is 0.
// An inter-byte timeout returns the block to IDLE so a dropped byte cannot
// leave the parameter fields permanently misaligned.
module uart_param_framer #(
    parameter int          PARAM_BYTES    = 26,
    parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
    parameter int          TIMEOUT_CYCLES = 100000
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [7:0]                 rx_data,
    input  logic                       rx_valid,
    output logic [8*PARAM_BYTES-1:0]   params,
    output logic                       params_valid,
    output logic                       busy,
    output logic                       frame_error,
    output logic [1:0]                 error_code,
    output logic [7:0]                 good_count,
    output logic [7:0]                 bad_count
);

    localparam int             TW         = $clog2(TIMEOUT_CYCLES);
    localparam logic [TW-1:0]  TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [7:0]     LAST_IDX   = 8'(PARAM_BYTES - 1);
    localparam logic [1:0]     EC_CHECKSUM = 2'd1;
    localparam logic [1:0]     EC_TIMEOUT  = 2'd2;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PAYLOAD = 2'd1,
        CHECK   = 2'd2
    } state_t;

    state_t                    state_q,        state_d;
    logic [7:0]                idx_q,          idx_d;
    logic [7:0]                sum_q,          sum_d;
    logic [TW-1:0]             timer_q,        timer_d;
    logic [8*PARAM_BYTES-1:0]  shadow_q,       shadow_d;
    logic [8*PARAM_BYTES-1:0]  params_q,       params_d;
    logic                      params_valid_q, params_valid_d;
    logic                      frame_error_q,  frame_error_d;
    logic [1:0]                error_code_q,   error_code_d;
    logic [7:0]                good_count_q,   good_count_d;
    logic [7:0]                bad_count_q,    bad_count_d;

    logic                      lane_wr;
    logic                      timeout_hit;
    logic [7:0]                check_sum;

    assign lane_wr     = (state_q == PAYLOAD) && rx_valid;
    // A byte arriving on the limit cycle wins over the timeout.
    assign timeout_hit = (state_q != IDLE) && !rx_valid && (timer_q == TIMER_LAST);
    assign check_sum   = sum_q + rx_data;

    // Shadow buffer lanes: the first payload byte lands in the most significant lane.
    genvar gi;
    generate
        for (gi = 0; gi < PARAM_BYTES; gi++) begin : g_lane
            localparam logic [7:0] LANE_IDX = 8'(PARAM_BYTES - 1 - gi);
            assign shadow_d[8*gi +: 8] = (lane_wr && (idx_q == LANE_IDX)) ? rx_data
                                                                          : shadow_q[8*gi +: 8];
        end
    endgenerate

    // Next-state and output computation for the framing FSM.
    always_comb begin
        state_d        = state_q;
        idx_d          = idx_q;
        sum_d          = sum_q;
        timer_d        = timer_q;
        params_d       = params_q;
        params_valid_d = 1'b0;
        frame_error_d  = 1'b0;
        error_code_d   = error_code_q;
        good_count_d   = good_count_q;
        bad_count_d    = bad_count_q;

        case (state_q)
            IDLE: begin
                timer_d = '0;
                if (rx_valid && (rx_data == SYNC_BYTE)) begin
                    state_d = PAYLOAD;
                    idx_d   = 8'd0;
                    sum_d   = 8'd0;
                end
            end
            PAYLOAD: begin
                if (rx_valid) begin
                    timer_d = '0;
                    sum_d   = sum_q + rx_data;
                    if (idx_q == LAST_IDX) begin
                        state_d = CHECK;
                    end else begin
                        idx_d = idx_q + 8'd1;
                    end
                end else if (timeout_hit) begin
                    state_d = IDLE;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            CHECK: begin
                if (rx_valid) begin
                    timer_d = '0;
                    state_d = IDLE;
                    if (check_sum == 8'd0) begin
                        params_d       = shadow_q;
                        params_valid_d = 1'b1;
                        if (good_count_q != 8'hFF) good_count_d = good_count_q + 8'd1;
                    end else begin
                        frame_error_d = 1'b1;
                        error_code_d  = EC_CHECKSUM;
                        if (bad_count_q != 8'hFF) bad_count_d = bad_count_q + 8'd1;
                    end
                end else if (timeout_hit) begin
                    state_d = IDLE;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            default: begin
                state_d = IDLE;
                timer_d = '0;
            end
        endcase

        if (timeout_hit) begin
            timer_d       = '0;
            frame_error_d = 1'b1;
            error_code_d  = EC_TIMEOUT;
            if (bad_count_q != 8'hFF) bad_count_d = bad_count_q + 8'd1;
        end
    end

    // State and output registers; reset aborts any frame without an error pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= IDLE;
            idx_q          <= 8'd0;
            sum_q          <= 8'd0;
            timer_q        <= '0;
            shadow_q       <= '0;
            params_q       <= '0;
            params_valid_q <= 1'b0;
            frame_error_q  <= 1'b0;
            error_code_q   <= 2'd0;
            good_count_q   <= 8'd0;
            bad_count_q    <= 8'd0;
        end else begin
            state_q        <= state_d;
            idx_q          <= idx_d;
            sum_q          <= sum_d;
            timer_q        <= timer_d;
            shadow_q       <= shadow_d;
            params_q       <= params_d;
            params_valid_q <= params_valid_d;
            frame_error_q  <= frame_error_d;
            error_code_q   <= error_code_d;
            good_count_q   <= good_count_d;
            bad_count_q    <= bad_count_d;
        end
    end

    assign params       = params_q;
    assign params_valid = params_valid_q;
    assign frame_error  = frame_error_q;
    assign error_code   = error_code_q;
    assign good_count   = good_count_q;
    assign bad_count    = bad_count_q;
    assign busy         = (state_q != IDLE);

endmodule

// File: tb/tb_uart_param_framer.sv
// Self-checking bench for uart_param_framer: a scoreboard of expected
// parameter blocks and error events (with their expected arrival cycle)
// is filled as frames are driven and drained by a negedge monitor.
`timescale 1ns/1ps
module tb_uart_param_framer;

    localparam int P  = 26;
    localparam int T  = 200;
    localparam int PW = 8 * P;

    logic           clk = 1'b0;
    logic           reset;
    logic [7:0]     rx_data;
    logic           rx_valid;
    logic [PW-1:0]  params;
    logic           params_valid;
    logic           busy;
    logic           frame_error;
    logic [1:0]     error_code;
    logic [7:0]     good_count;
    logic [7:0]     bad_count;

    uart_param_framer #(
        .PARAM_BYTES    (P),
        .SYNC_BYTE      (8'hA5),
        .TIMEOUT_CYCLES (T)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .params       (params),
        .params_valid (params_valid),
        .busy         (busy),
        .frame_error  (frame_error),
        .error_code   (error_code),
        .good_count   (good_count),
        .bad_count    (bad_count)
    );

    always #5 clk = ~clk;

    typedef struct packed { logic [PW-1:0] data; logic [31:0] cyc; } pexp_t;
    typedef struct packed { logic [1:0] code; logic [31:0] cyc; } eexp_t;

    pexp_t       pq[$];
    eexp_t       eq[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    int          pv_seen  = 0;
    logic [31:0] cyc      = 0;

    // Reference model state
    logic [7:0]    exp_good;
    logic [7:0]    exp_bad;
    logic [1:0]    exp_ec;
    logic [PW-1:0] last_good;

    task automatic check_eq(input string tag, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: drain the scoreboard whenever the DUT reports a result.
    always @(negedge clk) begin
        if (params_valid) begin
            pv_seen++;
            if (pq.size() == 0) begin
                check_eq("pv_unexpected", params_valid, 0);
            end else begin
                pexp_t e;
                e = pq.pop_front();
                check_eq("params", params, e.data);
                check_eq("pv_cycle", cyc, e.cyc);
            end
        end
        if (frame_error) begin
            if (eq.size() == 0) begin
                check_eq("fe_unexpected", frame_error, 0);
            end else begin
                eexp_t e;
                e = eq.pop_front();
                check_eq("error_code", error_code, e.code);
                check_eq("fe_cycle", cyc, e.cyc);
            end
        end
    end

    task automatic send_byte(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_frame(input string name, input logic [PW-1:0] payload, input bit corrupt);
        logic [7:0] s;
        logic [7:0] b;
        logic [7:0] c;
        s = 8'd0;
        send_byte(8'hA5);
        for (int i = 0; i < P; i++) begin
            b = payload[8*(P-1-i) +: 8];
            s = s + b;
            send_byte(b);
        end
        c = 8'd0 - s;
        if (corrupt) begin
            c = c + 8'd1;
            eq.push_back('{code: 2'd1, cyc: cyc + 1});
            exp_ec  = 2'd1;
            exp_bad = (exp_bad == 8'hFF) ? 8'hFF : exp_bad + 8'd1;
        end else begin
            pq.push_back('{data: payload, cyc: cyc + 1});
            last_good = payload;
            exp_good  = (exp_good == 8'hFF) ? 8'hFF : exp_good + 8'd1;
        end
        $display("frame %s chk=%02h corrupt=%0d payload=%0h", name, c, corrupt, payload);
        send_byte(c);
    endtask

    task automatic check_state(input string tag);
        check_eq({tag, "_good_count"}, good_count, exp_good);
        check_eq({tag, "_bad_count"},  bad_count,  exp_bad);
        check_eq({tag, "_error_code"}, error_code, exp_ec);
        check_eq({tag, "_params"},     params,     last_good);
        check_eq({tag, "_busy"},       busy,       0);
    endtask

    function automatic logic [PW-1:0] rand_payload();
        logic [PW-1:0] p;
        for (int i = 0; i < P; i++) p[8*i +: 8] = 8'($urandom_range(0, 255));
        return p;
    endfunction

    initial begin
        #(30000 * 10);
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [PW-1:0] pay;
        int            pv_before;

        reset     = 1'b1;
        rx_data   = 8'd0;
        rx_valid  = 1'b0;
        exp_good  = 8'd0;
        exp_bad   = 8'd0;
        exp_ec    = 2'd0;
        last_good = '0;
        idle(3);
        reset = 1'b0;
        idle(1);
        check_state("reset");
        check_eq("reset_pv", params_valid, 0);
        check_eq("reset_fe", frame_error, 0);

        // Good frame 01..1A
        for (int i = 0; i < P; i++) pay[8*(P-1-i) +: 8] = 8'(i + 1);
        send_frame("incrementing", pay, 1'b0);
        idle(2);
        check_eq("first_byte_msb", params[207:200], 8'h01);
        check_eq("last_byte_lsb",  params[7:0],     8'h1A);
        check_state("good1");

        // Same payload, checksum off by one
        send_frame("bad_checksum", pay, 1'b1);
        idle(2);
        check_state("cksum_err");

        // Timeout after 10 payload bytes
        send_byte(8'hA5);
        for (int i = 0; i < 9; i++) send_byte(8'(8'h30 + i));
        eq.push_back('{code: 2'd2, cyc: cyc + 1 + T});
        exp_ec  = 2'd2;
        exp_bad = exp_bad + 8'd1;
        $display("partial frame of 10 bytes, expecting timeout");
        send_byte(8'h39);
        check_eq("busy_mid_frame", busy, 1);
        idle(T + 5);
        check_state("timeout");
        send_frame("after_timeout", rand_payload(), 1'b0);
        idle(2);
        check_state("post_timeout");

        // Garbage in IDLE is ignored, then a good frame
        send_byte(8'h00);
        send_byte(8'hFF);
        send_byte(8'h13);
        $display("garbage bytes 00 FF 13 sent");
        check_eq("garbage_busy", busy, 0);
        send_frame("after_garbage", rand_payload(), 1'b0);
        idle(2);
        check_state("garbage");

        // Payload carrying SYNC_BYTE values
        pay = rand_payload();
        pay[8*(P-1) +: 8] = 8'hA5;
        pay[8*(P-6) +: 8] = 8'hA5;
        pay[7:0]          = 8'hA5;
        send_frame("sync_in_payload", pay, 1'b0);
        idle(2);
        check_eq("a5_msb", params[207:200], 8'hA5);
        check_eq("a5_b5",  params[8*(P-6) +: 8], 8'hA5);
        check_eq("a5_lsb", params[7:0], 8'hA5);
        check_state("sync_payload");

        // 300 back-to-back good frames, good_count saturates
        pv_before = pv_seen;
        for (int f = 0; f < 300; f++) send_frame("b2b", rand_payload(), 1'b0);
        idle(2);
        check_eq("b2b_pv_pulses", pv_seen - pv_before, 300);
        check_eq("sat_good_count", good_count, 8'd255);
        check_state("saturation");

        // Reset in the middle of a frame
        send_byte(8'hA5);
        for (int i = 0; i < 5; i++) send_byte(8'(i + 8'h50));
        $display("reset mid-frame");
        reset = 1'b1;
        idle(1);
        reset     = 1'b0;
        exp_good  = 8'd0;
        exp_bad   = 8'd0;
        exp_ec    = 2'd0;
        last_good = '0;
        check_state("mid_reset");
        check_eq("mid_reset_pv", params_valid, 0);
        check_eq("mid_reset_fe", frame_error, 0);
        send_frame("after_reset", rand_payload(), 1'b0);
        idle(2);
        check_eq("after_reset_good", good_count, 8'd1);
        check_state("after_reset");

        idle(T + 5);
        check_eq("pq_drained", pq.size(), 0);
        check_eq("eq_drained", eq.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
